// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: opcodes, trailer/status layout, header fields and FSM states for the command sequencer
package reg_cmd_pkg;
  localparam logic [3:0] OP_WRITE    = 4'd1;
  localparam logic [3:0] OP_READ     = 4'd2;
  localparam logic [3:0] TRAILER_TAG = 4'hA;
  localparam int STATUS_ILLEGAL   = 0;
  localparam int STATUS_TIMEOUT   = 1;
  localparam int STATUS_BAD_OP    = 2;
  localparam int STATUS_BAD_COUNT = 3;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int CNT_HI = 27;
  localparam int CNT_LO = 16;
  localparam int TAG_HI = 15;
  localparam int TAG_LO = 0;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_ADDR, S_LOAD, S_CHK, S_WR, S_RD, S_RCAP, S_PUSH, S_DRAIN, S_TRL, S_TRL2
  } state_t;
endpackage

// File: rtl/cmd_watchdog.sv
// cmd_watchdog: loadable down-counter; expire fires on the TIMEOUT-th consecutive enabled cycle after a clear
module cmd_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= 16'(TIMEOUT - 1);
    else if (en && cnt != '0) cnt <= cnt - 16'd1;
  end
  assign expire = en && !clr && cnt == '0;
endmodule

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: parses framed register commands from the RX FIFO, drives register strobes, streams read data and trailer to TX
module reg_cmd_sequencer
  import reg_cmd_pkg::*;
#(
  parameter int MAX_COUNT = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_word,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [31:0] tx_word,
  output logic        tx_push,
  input  logic        tx_full,
  output logic [31:0] reg_data,
  output logic        reg_num_le,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rd_data,
  input  logic        illegal_reg_num,
  output logic        busy
);
  state_t      state, nxt;
  logic [3:0]  op, status, hdr_op;
  logic [11:0] cnt, done, popped, tag;
  logic [31:0] addr, hold;
  logic        wait_st, expire, op_ok, cnt_bad, last;
  assign hdr_op  = rx_word[OP_HI:OP_LO];
  assign op_ok   = hdr_op == OP_WRITE || hdr_op == OP_READ;
  assign cnt_bad = cnt == '0 || cnt > 12'(MAX_COUNT);
  assign last    = done + 12'd1 == cnt;
  assign wait_st = state inside {S_ADDR, S_WR, S_DRAIN};
  cmd_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (rx_pop || !wait_st),
    .en     (wait_st && !rx_valid),
    .expire (expire)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = rx_valid ? S_HDR : S_IDLE;
      S_HDR:   nxt = !rx_valid ? S_HDR : op_ok ? S_ADDR : S_TRL;
      S_ADDR:  nxt = rx_valid ? (cnt_bad ? S_TRL : S_LOAD) : expire ? S_TRL : S_ADDR;
      S_LOAD:  nxt = S_CHK;
      S_CHK:   nxt = illegal_reg_num ? (op == OP_WRITE ? S_DRAIN : S_TRL) : (op == OP_WRITE ? S_WR : S_RD);
      S_WR:    nxt = rx_valid ? (last ? S_TRL : S_LOAD) : expire ? S_TRL : S_WR;
      S_RD:    nxt = S_RCAP;
      S_RCAP:  nxt = S_PUSH;
      S_PUSH:  nxt = tx_full ? S_PUSH : last ? S_TRL : S_LOAD;
      S_DRAIN: nxt = rx_valid ? (popped + 12'd1 == cnt ? S_TRL : S_DRAIN) : expire ? S_TRL : S_DRAIN;
      S_TRL:   nxt = tx_full ? S_TRL : S_TRL2;
      S_TRL2:  nxt = tx_full ? S_TRL2 : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  assign rx_pop     = rx_valid && state inside {S_HDR, S_ADDR, S_WR, S_DRAIN};
  assign reg_num_le = state == S_LOAD;
  assign reg_wr_en  = state == S_WR && rx_valid;
  assign reg_rd_en  = state == S_RD;
  assign reg_data   = reg_wr_en ? rx_word : reg_num_le ? addr : '0;
  assign tx_push    = !tx_full && state inside {S_PUSH, S_TRL, S_TRL2};
  assign tx_word    = state == S_PUSH ? hold :
                      state == S_TRL  ? {TRAILER_TAG, op, done, tag} :
                      state == S_TRL2 ? {28'd0, status} : '0;
  assign busy       = state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op     <= '0;
      cnt    <= '0;
      tag    <= '0;
      addr   <= '0;
      hold   <= '0;
      done   <= '0;
      popped <= '0;
      status <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE) begin
        done   <= '0;
        popped <= '0;
        status <= '0;
      end
      if (state == S_HDR && rx_valid) begin
        op  <= hdr_op;
        cnt <= rx_word[CNT_HI:CNT_LO];
        tag <= rx_word[TAG_LO+11:TAG_LO];
        if (!op_ok) status[STATUS_BAD_OP] <= 1'b1;
      end
      if (state == S_ADDR && rx_valid) begin
        addr <= rx_word;
        if (cnt_bad) status[STATUS_BAD_COUNT] <= 1'b1;
      end
      if (expire) status[STATUS_TIMEOUT] <= 1'b1;
      if (state == S_CHK && illegal_reg_num) status[STATUS_ILLEGAL] <= 1'b1;
      if (reg_wr_en) begin
        done   <= done + 12'd1;
        popped <= popped + 12'd1;
        addr   <= addr + 32'd1;
      end
      if (state == S_DRAIN && rx_valid) popped <= popped + 12'd1;
      if (state == S_RCAP) hold <= reg_rd_data;
      // a read word only counts once it has actually left for the TX FIFO
      if (state == S_PUSH && !tx_full) begin
        done <= done + 12'd1;
        addr <= addr + 32'd1;
      end
    end
  end
endmodule
